// File: rtl/ahb_slave_phase_ctrl.sv
// ahb_slave_phase_ctrl
//
// AHB-Lite slave front end that sits directly ahead of the address decoder. It captures the
// address phase into haddr_reg/hsize_reg/hwrite_reg, sequences the data phase, and drives
// HREADYOUT/HRESP. Buffer reads that would underflow are held with wait states for up to
// MAX_WAIT cycles and then fail. Illegal accesses get the two-cycle ERROR response.
// rd_en/wr_en pulse for exactly one cycle when a data phase completes with OKAY.
//
// Ports
//   clk               system clock, rising edge
//   n_rst             synchronous active-low reset
//   hsel              slave select
//   htrans[1:0]       0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   haddr[3:0]        byte address (address phase)
//   hsize[1:0]        0 byte, 1 half, 2 word, 3 reserved
//   hwrite            1 write, 0 read
//   buffer_occupancy  bytes currently held in the data buffer
//   hready            HREADYOUT, 1 completes the current data phase
//   hresp             0 OKAY, 1 ERROR
//   haddr_reg         address of the transfer in data phase
//   hsize_reg         size of the transfer in data phase
//   hwrite_reg        direction of the transfer in data phase
//   rd_en             one-cycle strobe, read data phase completes OKAY
//   wr_en             one-cycle strobe, write data phase completes OKAY
//
// All outputs are decoded from registered state only (state, captured address phase and the
// occupancy input for the underflow check), so a legal transfer completes with zero wait states.

module ahb_slave_phase_ctrl #(
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned OCC_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [3:0]           haddr,
    input  logic [1:0]           hsize,
    input  logic                 hwrite,
    input  logic [OCC_WIDTH-1:0] buffer_occupancy,
    output logic                 hready,
    output logic                 hresp,
    output logic [3:0]           haddr_reg,
    output logic [1:0]           hsize_reg,
    output logic                 hwrite_reg,
    output logic                 rd_en,
    output logic                 wr_en
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StWait,
        StDone,
        StErr1,
        StErr2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      haddr_q, haddr_d;
    logic [1:0]      hsize_q, hsize_d;
    logic            hwrite_q, hwrite_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    logic                 ready_c;
    logic                 resp_c;
    logic                 rd_c;
    logic                 wr_c;
    logic                 trans_active;
    logic                 accept;
    logic                 addr_bad;
    logic                 ro_region;
    logic                 illegal;
    logic                 underflow;
    logic [OCC_WIDTH-1:0] need_bytes;

    // Access checks on the captured address phase.
    always_comb begin
        addr_bad   = haddr_q inside {4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
        ro_region  = haddr_q inside {[4'h4:4'h8]};
        illegal    = addr_bad || (hsize_q == 2'd3) || (hwrite_q && ro_region);
        // A read of 2^hsize bytes from the buffer window needs that many bytes present.
        need_bytes = OCC_WIDTH'(1) << hsize_q;
        underflow  = !hwrite_q && (haddr_q <= 4'h3) && (buffer_occupancy < need_bytes);
    end

    // NONSEQ and SEQ start a transfer; IDLE and BUSY never do.
    assign trans_active = (htrans == 2'b10) || (htrans == 2'b11);

    always_comb begin
        ready_c    = 1'b1;
        resp_c     = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        haddr_d    = haddr_q;
        hsize_d    = hsize_q;
        hwrite_d   = hwrite_q;

        unique case (state_q)
            StIdle: begin
                // Bus idle: ready, OKAY.
            end
            StData: begin
                if (illegal) begin
                    ready_c = 1'b0;
                    state_d = StErr1;
                end else if (underflow) begin
                    ready_c    = 1'b0;
                    state_d    = StWait;
                    wait_cnt_d = CntW'(1);
                end else begin
                    rd_c = !hwrite_q;
                    wr_c = hwrite_q;
                end
            end
            StWait: begin
                ready_c = 1'b0;
                if (!underflow) begin
                    state_d = StDone;
                end else if (wait_cnt_q == CntW'(MAX_WAIT)) begin
                    state_d = StErr1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // Stalled read finally completes; only reads ever stall.
                rd_c = 1'b1;
            end
            StErr1: begin
                ready_c = 1'b0;
                resp_c  = 1'b1;
                state_d = StErr2;
            end
            StErr2: begin
                resp_c = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any cycle that ends with hready high closes the data phase and samples the next
        // address phase, which gives pipelined back-to-back transfers.
        accept = ready_c && hsel && trans_active;
        if (ready_c) begin
            if (accept) begin
                state_d    = StData;
                haddr_d    = haddr;
                hsize_d    = hsize;
                hwrite_d   = hwrite;
                wait_cnt_d = '0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            haddr_q    <= '0;
            hsize_q    <= '0;
            hwrite_q   <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hready     = ready_c;
    assign hresp      = resp_c;
    assign rd_en      = rd_c;
    assign wr_en      = wr_c;
    assign haddr_reg  = haddr_q;
    assign hsize_reg  = hsize_q;
    assign hwrite_reg = hwrite_q;

endmodule

// File: tb/tb_ahb_slave_phase_ctrl.sv
// Scoreboard bench for ahb_slave_phase_ctrl. Stimulus pushes one expected response per issued
// transfer; the monitor pops one entry each time the slave finishes a data phase.

module tb_ahb_slave_phase_ctrl;

    localparam int unsigned MaxWait = 8;
    localparam int unsigned OccW    = 7;

    localparam logic [2:0] KRd  = 3'b001;
    localparam logic [2:0] KWr  = 3'b010;
    localparam logic [2:0] KErr = 3'b100;

    logic            clk;
    logic            n_rst;
    logic            hsel;
    logic [1:0]      htrans;
    logic [3:0]      haddr;
    logic [1:0]      hsize;
    logic            hwrite;
    logic [OccW-1:0] occ;
    logic            hready;
    logic            hresp;
    logic [3:0]      haddr_reg;
    logic [1:0]      hsize_reg;
    logic            hwrite_reg;
    logic            rd_en;
    logic            wr_en;

    ahb_slave_phase_ctrl #(
        .MAX_WAIT  (MaxWait),
        .OCC_WIDTH (OccW)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .hsel             (hsel),
        .htrans           (htrans),
        .haddr            (haddr),
        .hsize            (hsize),
        .hwrite           (hwrite),
        .buffer_occupancy (occ),
        .hready           (hready),
        .hresp            (hresp),
        .haddr_reg        (haddr_reg),
        .hsize_reg        (hsize_reg),
        .hwrite_reg       (hwrite_reg),
        .rd_en            (rd_en),
        .wr_en            (wr_en)
    );

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] addr;
        logic [1:0] size;
        logic [7:0] lows;     // hready-low cycles before the completing cycle
        logic [7:0] errlows;  // of those, cycles with hresp high
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   mon_en     = 1'b0;
    int   low_cnt    = 0;
    int   err_cnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tr(input logic [2:0] k, input logic [3:0] a, input logic [1:0] s,
                             input int l, input int e);
        exp_t x;
        x.kind    = k;
        x.addr    = a;
        x.size    = s;
        x.lows    = 8'(l);
        x.errlows = 8'(e);
        exp_q.push_back(x);
    endtask

    // Present an address phase and hold it until the slave takes it (hready high at the edge).
    task automatic issue(input logic w, input logic [3:0] a, input logic [1:0] s,
                         input logic [1:0] t);
        int n;
        hsel   = 1'b1;
        htrans = t;
        haddr  = a;
        hsize  = s;
        hwrite = w;
        n = 0;
        @(negedge clk);
        while (hready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: hready low %0d cycles, expected release", n);
        end
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // Monitor: one scoreboard pop per completed data phase.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hready !== 1'b1) begin
                check("no_strobe_while_stalled", {30'd0, rd_en, wr_en}, 32'd0);
                low_cnt++;
                if (hresp === 1'b1) err_cnt++;
            end else begin
                if ((rd_en | wr_en | hresp) === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_response: rd=%0b wr=%0b resp=%0b addr=0x%0h",
                                 rd_en, wr_en, hresp, haddr_reg);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        check("resp_kind", {29'd0, hresp, wr_en, rd_en}, {29'd0, x.kind});
                        check("haddr_reg", {28'd0, haddr_reg}, {28'd0, x.addr});
                        check("hsize_reg", {30'd0, hsize_reg}, {30'd0, x.size});
                        check("wait_cycles", low_cnt, {24'd0, x.lows});
                        check("err1_cycles", err_cnt, {24'd0, x.errlows});
                    end
                end
                low_cnt = 0;
                err_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        n_rst  = 1'b0;
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 4'h0;
        hsize  = 2'd0;
        hwrite = 1'b0;
        occ    = '0;

        // Reset values after two reset edges.
        tick();
        tick();
        check("rst_hready", {31'd0, hready}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_haddr_reg", {28'd0, haddr_reg}, 32'd0);
        check("rst_hsize_reg", {30'd0, hsize_reg}, 32'd0);
        check("rst_hwrite_reg", {31'd0, hwrite_reg}, 32'd0);
        check("rst_strobes", {30'd0, rd_en, wr_en}, 32'd0);
        n_rst  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Zero-wait write, then idle.
        expect_tr(KWr, 4'hC, 2'd0, 0, 0);
        issue(1'b1, 4'hC, 2'd0, 2'b10);
        repeat (3) tick();

        // BUSY and deselected NONSEQ must not be accepted; registers hold.
        hsel = 1'b1; htrans = 2'b01; haddr = 4'h1; hwrite = 1'b0;
        repeat (3) tick();
        hsel = 1'b0; htrans = 2'b10;
        repeat (2) tick();
        htrans = 2'b00;
        check("busy_not_accepted", {28'd0, haddr_reg}, 32'hC);

        // Underflowing word read released after three low cycles.
        occ = 7'd2;
        expect_tr(KRd, 4'h0, 2'd2, 3, 0);
        issue(1'b0, 4'h0, 2'd2, 2'b10);
        tick();
        tick();
        occ = 7'd4;
        repeat (4) tick();

        // Occupancy stuck: DATA + MAX_WAIT wait cycles, then ERR1/ERR2.
        occ = 7'd1;
        expect_tr(KErr, 4'h0, 2'd2, 1 + MaxWait + 1, 1);
        issue(1'b0, 4'h0, 2'd2, 2'b10);
        repeat (MaxWait + 4) tick();

        // Exact-fit byte read with occupancy 1 does not stall.
        expect_tr(KRd, 4'h1, 2'd0, 0, 0);
        issue(1'b0, 4'h1, 2'd0, 2'b10);
        repeat (2) tick();

        // Writes into the buffer window never stall, even when empty.
        occ = 7'd0;
        expect_tr(KWr, 4'h3, 2'd1, 0, 0);
        issue(1'b1, 4'h3, 2'd1, 2'b10);
        repeat (2) tick();

        // Illegal accesses back to back; each new one is taken in ERR2.
        expect_tr(KErr, 4'h5, 2'd0, 2, 1);
        issue(1'b1, 4'h5, 2'd0, 2'b10);
        expect_tr(KErr, 4'hA, 2'd0, 2, 1);
        issue(1'b0, 4'hA, 2'd0, 2'b10);
        expect_tr(KErr, 4'hC, 2'd3, 2, 1);
        issue(1'b0, 4'hC, 2'd3, 2'b10);
        expect_tr(KErr, 4'h8, 2'd0, 2, 1);
        issue(1'b1, 4'h8, 2'd0, 2'b10);
        repeat (4) tick();

        // Pipelined NONSEQ read 0x8 then SEQ read 0x4.
        occ = 7'd64;
        expect_tr(KRd, 4'h8, 2'd2, 0, 0);
        issue(1'b0, 4'h8, 2'd2, 2'b10);
        expect_tr(KRd, 4'h4, 2'd2, 0, 0);
        issue(1'b0, 4'h4, 2'd2, 2'b11);
        repeat (3) tick();

        // Reset during WAIT drops the transfer; no scoreboard entry.
        occ = 7'd0;
        issue(1'b0, 4'h2, 2'd0, 2'b10);
        tick();
        n_rst = 1'b0;
        tick();
        check("midrst_hready", {31'd0, hready}, 32'd1);
        check("midrst_hresp", {31'd0, hresp}, 32'd0);
        check("midrst_strobes", {30'd0, rd_en, wr_en}, 32'd0);
        check("midrst_haddr_reg", {28'd0, haddr_reg}, 32'd0);
        n_rst = 1'b1;
        tick();

        // Recovery after reset.
        expect_tr(KWr, 4'hD, 2'd2, 0, 0);
        issue(1'b1, 4'hD, 2'd2, 2'b10);
        repeat (3) tick();

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
